// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and helpers for the SPI bus arbiter slice.
package spi_arb_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_GUARD
    } arb_state_t;

    function automatic logic [MAX_REQ-1:0] one_hot(input int unsigned idx);
        logic [MAX_REQ-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            v[i] = (i == idx);
        end
        return v;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and SPI-master-side signals of the arbiter.
// The master modport is the environment (sensor FSMs + SPI master), the slave modport is the arbiter.
interface spi_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import spi_arb_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        req_begin;
    logic [BYTE_W*NUM_REQ-1:0] req_send_data;
    logic [NUM_REQ-1:0]        req_ss;
    logic [NUM_REQ-1:0]        req_end;
    logic [BYTE_W-1:0]         req_recv_data;
    logic                      spi_begin;
    logic [BYTE_W-1:0]         spi_send_data;
    logic                      spi_end;
    logic [BYTE_W-1:0]         spi_recv_data;
    logic [NUM_REQ-1:0]        ss_n;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output req, req_begin, req_send_data, req_ss, spi_end, spi_recv_data,
        input  grant, req_end, req_recv_data, spi_begin, spi_send_data, ss_n, busy, timeout_err
    );

    modport slave (
        input  req, req_begin, req_send_data, req_ss, spi_end, spi_recv_data,
        output grant, req_end, req_recv_data, spi_begin, spi_send_data, ss_n, busy, timeout_err
    );

endinterface

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] rot;
    int unsigned          sum;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = 0;
        // Doubling the vector makes the wrap-around a plain right shift.
        rot   = {req, req} >> ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                sum   = 32'(ptr) + i;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                idx = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one SPI master shared by NUM_REQ sensor FSMs,
// with a slave-select guard gap between owners and a hold-time watchdog.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter logic [23:0] MAX_HOLD     = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    spi_bus_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned GW    = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [23:0]   HOLD_LAST  = MAX_HOLD - 24'd1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                in_flight_q, in_flight_d;
    logic [23:0]         hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]       guard_cnt_q, guard_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                timeout_q, timeout_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [MAX_REQ-1:0]  pick_oh;

    logic                owner_req, owner_begin, owner_ss, end_ok;
    logic [BYTE_W-1:0]   owner_byte;
    logic [NUM_REQ-1:0]  ss_n_c, req_end_c;
    logic                spi_begin_c;
    logic [BYTE_W-1:0]   spi_send_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        owner_req   = 1'b0;
        owner_begin = 1'b0;
        owner_ss    = 1'b1;
        owner_byte  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req   = bus.req[i];
                owner_begin = bus.req_begin[i];
                owner_ss    = bus.req_ss[i];
                owner_byte  = bus.req_send_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        in_flight_d = in_flight_q;
        hold_cnt_d  = hold_cnt_q;
        guard_cnt_d = guard_cnt_q;
        grant_d     = grant_q;
        timeout_d   = 1'b0;
        pick_oh     = '0;
        end_ok      = 1'b0;
        ss_n_c      = '1;
        req_end_c   = '0;
        spi_begin_c = 1'b0;
        spi_send_c  = '0;

        unique case (state_q)
            ARB_IDLE: begin
                in_flight_d = 1'b0;
                hold_cnt_d  = '0;
                guard_cnt_d = '0;
                grant_d     = '0;
                if (pick_valid) begin
                    pick_oh  = one_hot(32'(pick_idx));
                    state_d  = ARB_GRANT;
                    owner_d  = pick_idx;
                    grant_d  = pick_oh[NUM_REQ-1:0];
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end

            ARB_GRANT: begin
                spi_begin_c = owner_begin;
                spi_send_c  = owner_byte;
                // An end pulse only counts if a byte is actually on the wire.
                end_ok      = bus.spi_end && (in_flight_q || owner_begin);
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (owner_q == IDX_W'(i)) begin
                        ss_n_c[i]    = owner_ss;
                        req_end_c[i] = end_ok;
                    end
                end
                if (end_ok) begin
                    in_flight_d = 1'b0;
                end else if (owner_begin) begin
                    in_flight_d = 1'b1;
                end
                hold_cnt_d = (hold_cnt_q == MAX_HOLD) ? hold_cnt_q : hold_cnt_q + 24'd1;
                if (!in_flight_d && (!owner_req || hold_cnt_q >= HOLD_LAST)) begin
                    state_d     = ARB_GUARD;
                    grant_d     = '0;
                    guard_cnt_d = '0;
                    timeout_d   = owner_req;
                end
            end

            ARB_GUARD: begin
                grant_d = '0;
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d = ARB_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            in_flight_q <= 1'b0;
            hold_cnt_q  <= '0;
            guard_cnt_q <= '0;
            grant_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            in_flight_q <= in_flight_d;
            hold_cnt_q  <= hold_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            grant_q     <= grant_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.ss_n          = ss_n_c;
    assign bus.req_end       = req_end_c;
    assign bus.req_recv_data = bus.spi_recv_data;
    assign bus.spi_begin     = spi_begin_c;
    assign bus.spi_send_data = spi_send_c;
    assign bus.busy          = (state_q != ARB_IDLE);
    assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (NUM_REQ=2, GUARD_CYCLES=16, MAX_HOLD=100).
module tb_spi_bus_arbiter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    spi_bus_arbiter_if #(.NUM_REQ(2)) bus ();

    spi_bus_arbiter #(
        .NUM_REQ      (2),
        .GUARD_CYCLES (16),
        .MAX_HOLD     (24'd100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req           = '0;
        bus.req_begin     = '0;
        bus.req_send_data = '0;
        bus.req_ss        = '1;
        bus.spi_end       = 1'b0;
        bus.spi_recv_data = '0;
    endtask

    // Reset with the given request vector already present when reset releases.
    task automatic do_reset(input logic [1:0] req_at_release);
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        bus.req = req_at_release;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tests_run++;
        if (bus.grant !== 2'b00) begin
            tests_failed++; $display("FAIL reset_grant got=%b exp=00", bus.grant);
        end
        tests_run++;
        if (bus.ss_n !== 2'b11) begin
            tests_failed++; $display("FAIL reset_ss_n got=%b exp=11", bus.ss_n);
        end
        tests_run++;
        if ({bus.spi_begin, bus.busy, bus.timeout_err} !== 3'b000 || bus.spi_send_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs got begin/busy/to=%b data=%h exp=000 data=00",
                     {bus.spi_begin, bus.busy, bus.timeout_err}, bus.spi_send_data);
        end
    endtask

    task automatic test_spurious_idle();
        do_reset(2'b00);
        tick();
        bus.spi_end = 1'b1;
        #1;
        tests_run++;
        if (bus.req_end !== 2'b00) begin
            tests_failed++; $display("FAIL idle_spurious_end got=%b exp=00", bus.req_end);
        end
        tick();
        bus.spi_end = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_spurious_state got busy=%b grant=%b exp busy=0 grant=00", bus.busy, bus.grant);
        end
    endtask

    task automatic test_single();
        logic [7:0] bytes [3];
        bytes[0] = 8'h20; bytes[1] = 8'h0F; bytes[2] = 8'hE8;
        do_reset(2'b00);
        tick();
        bus.req = 2'b01;
        #1;
        tests_run++;
        if (bus.grant !== 2'b00) begin
            tests_failed++; $display("FAIL single_pre_grant got=%b exp=00", bus.grant);
        end
        tick();
        tests_run++;
        if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin
            tests_failed++; $display("FAIL single_grant got=%b busy=%b exp=01 busy=1", bus.grant, bus.busy);
        end
        // End pulse with nothing in flight must not reach the owner.
        bus.spi_end = 1'b1;
        #1;
        tests_run++;
        if (bus.req_end !== 2'b00) begin
            tests_failed++; $display("FAIL single_spurious_end got=%b exp=00", bus.req_end);
        end
        tick();
        bus.spi_end = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.req_begin     = 2'b11;
            bus.req_ss        = 2'b00;
            bus.req_send_data = {8'hAA, bytes[b]};
            #1;
            tests_run++;
            if (bus.spi_send_data !== bytes[b] || bus.spi_begin !== 1'b1 || bus.ss_n !== 2'b10) begin
                tests_failed++;
                $display("FAIL single_byte%0d got data=%h begin=%b ss_n=%b exp data=%h begin=1 ss_n=10",
                         b, bus.spi_send_data, bus.spi_begin, bus.ss_n, bytes[b]);
            end
            tick();
            tick();
            bus.spi_end       = 1'b1;
            bus.spi_recv_data = ~bytes[b];
            #1;
            tests_run++;
            if (bus.req_end !== 2'b01 || bus.req_recv_data !== ~bytes[b]) begin
                tests_failed++;
                $display("FAIL single_end%0d got req_end=%b recv=%h exp req_end=01 recv=%h",
                         b, bus.req_end, bus.req_recv_data, ~bytes[b]);
            end
            tick();
            bus.spi_end   = 1'b0;
            bus.req_begin = 2'b00;
            #1;
            tests_run++;
            if (bus.req_end !== 2'b00 || bus.grant !== 2'b01) begin
                tests_failed++;
                $display("FAIL single_after_end%0d got req_end=%b grant=%b exp req_end=00 grant=01",
                         b, bus.req_end, bus.grant);
            end
            tick();
        end
        bus.req    = 2'b00;
        bus.req_ss = 2'b11;
        tick();
        tests_run++;
        if (bus.grant !== 2'b00 || bus.ss_n !== 2'b11 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_release got grant=%b ss_n=%b busy=%b exp 00 11 1", bus.grant, bus.ss_n, bus.busy);
        end
        repeat (16) tick();
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL single_guard_end got busy=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        do_reset(2'b11);
        tick();
        for (int p = 0; p < 4; p++) begin
            tests_run++;
            if (bus.grant !== exp_seq[p]) begin
                tests_failed++; $display("FAIL contention_grant%0d got=%b exp=%b", p, bus.grant, exp_seq[p]);
            end
            if (p == 3) break;
            bus.req = 2'b11 & ~exp_seq[p];
            tick();
            bus.req = 2'b11;
            tests_run++;
            if (bus.grant !== 2'b00) begin
                tests_failed++; $display("FAIL contention_guard%0d got grant=%b exp=00", p, bus.grant);
            end
            repeat (15) tick();
            tests_run++;
            if (bus.busy !== 1'b1 || bus.grant !== 2'b00) begin
                tests_failed++;
                $display("FAIL contention_guard_hold%0d got busy=%b grant=%b exp 1 00", p, bus.busy, bus.grant);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_drop_mid_byte();
        int bad;
        do_reset(2'b01);
        tick();
        bus.req_begin     = 2'b01;
        bus.req_ss        = 2'b10;
        bus.req_send_data = 16'h005A;
        tick();
        bus.req = 2'b00;
        tick();
        tests_run++;
        if (bus.grant !== 2'b01 || bus.spi_begin !== 1'b1 || bus.ss_n !== 2'b10) begin
            tests_failed++;
            $display("FAIL drop_hold got grant=%b begin=%b ss_n=%b exp 01 1 10", bus.grant, bus.spi_begin, bus.ss_n);
        end
        tick();
        bus.spi_end = 1'b1;
        #1;
        tests_run++;
        if (bus.req_end !== 2'b01) begin
            tests_failed++; $display("FAIL drop_end_routed got=%b exp=01", bus.req_end);
        end
        tick();
        bus.spi_end   = 1'b0;
        bus.req_begin = 2'b00;
        bus.req_ss    = 2'b11;
        tests_run++;
        if (bus.grant !== 2'b00 || bus.spi_begin !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_to_guard got grant=%b begin=%b busy=%b exp 00 0 1", bus.grant, bus.spi_begin, bus.busy);
        end
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            bus.spi_end = (k == 5);
            if (k == 5) begin
                bus.req_begin = 2'b01;
                bus.req_ss    = 2'b00;
            end
            #1;
            if (bus.req_end !== 2'b00 || bus.ss_n !== 2'b11 || bus.spi_begin !== 1'b0) bad++;
            tick();
            bus.spi_end   = 1'b0;
            bus.req_begin = 2'b00;
            bus.req_ss    = 2'b11;
            if (bus.busy !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL drop_guard_window got bad_cycles=%0d exp=0", bad);
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL drop_guard_len got busy=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_timeout();
        do_reset(2'b11);
        tick();
        repeat (99) tick();
        tests_run++;
        if (bus.grant !== 2'b01 || bus.timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pre got grant=%b to=%b exp 01 0", bus.grant, bus.timeout_err);
        end
        tick();
        tests_run++;
        if (bus.grant !== 2'b00 || bus.timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_release got grant=%b to=%b exp 00 1", bus.grant, bus.timeout_err);
        end
        tick();
        tests_run++;
        if (bus.timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_pulse_width got to=%b exp=0", bus.timeout_err);
        end
        repeat (15) tick();
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_guard got busy=%b exp=0", bus.busy);
        end
        tick();
        tests_run++;
        if (bus.grant !== 2'b10) begin
            tests_failed++; $display("FAIL timeout_next_owner got=%b exp=10", bus.grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset(2'b01);
        tick();
        bus.req_begin     = 2'b01;
        bus.req_ss        = 2'b10;
        bus.req_send_data = 16'h0033;
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.ss_n !== 2'b11 || bus.grant !== 2'b00 || bus.spi_begin !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got ss_n=%b grant=%b begin=%b busy=%b exp 11 00 0 0",
                     bus.ss_n, bus.grant, bus.spi_begin, bus.busy);
        end
        bus.req       = 2'b11;
        bus.req_begin = 2'b00;
        bus.req_ss    = 2'b11;
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.grant !== 2'b01) begin
            tests_failed++; $display("FAIL async_reset_rr_restart got=%b exp=01", bus.grant);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear_inputs();
        test_reset();
        test_spurious_idle();
        test_single();
        test_contention();
        test_drop_mid_byte();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
